xif_result_arbiter: RTL and testbench
=====================================

XIF_RESULT_ARBITER -- requirements
Module: xif_result_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of coprocessor result requesters (2..8).
REQ-002 SHALL have parameter ID_WIDTH, default 4: width of the X-interface instruction id.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  NUM_REQ  per-requester result valid.
REQ-006 SHALL have port req_ready_o  output  NUM_REQ  per-requester result accepted this cycle.
REQ-007 SHALL have port req_id_i  input  NUM_REQ x ID_WIDTH  per-requester instruction id.
REQ-008 SHALL have port req_data_i  input  NUM_REQ x 32  per-requester writeback data.
REQ-009 SHALL have port req_rd_i  input  NUM_REQ x 5  per-requester destination register.
REQ-010 SHALL have port req_flags_i  input  NUM_REQ x 3  per-requester {we, float, exc}.
REQ-011 SHALL have port req_exccode_i  input  NUM_REQ x 6  per-requester exception code.
REQ-012 SHALL have port x_result_valid_o  output  1  result valid toward core.
REQ-013 SHALL have port x_result_ready_i  input  1  core accepts result.
REQ-014 SHALL have ports x_result_id_o/data_o/rd_o/flags_o/exccode_o  output  ID_WIDTH/32/5/3/6  registered result toward core.
REQ-015 SHALL have port x_result_src_o  output  clog2(NUM_REQ) (min 1)  index of requester owning current output.

Function
REQ-016 SHALL hold one output register (full/empty flag = x_result_valid_o) plus a round-robin pointer rr_q.
REQ-017 SHALL define can_load = !x_result_valid_o | x_result_ready_i.
REQ-018 SHALL, when can_load and any req_valid_i set, grant exactly one requester: first valid index at or after rr_q, wrapping modulo NUM_REQ.
REQ-019 SHALL assert req_ready_o[g] only for granted g, combinationally, in the grant cycle; all other bits 0; all 0 when !can_load.
REQ-020 SHALL load granted requester's id/data/rd/flags/exccode and src=g into the output register on the grant edge; latency request-to-output exactly 1 cycle.
REQ-021 SHALL update rr_q to (g+1) mod NUM_REQ on each grant; rr_q unchanged with no grant.
REQ-022 SHALL clear x_result_valid_o after x_result_valid_o & x_result_ready_i with no grant; hold all output fields stable while valid & !ready.
REQ-023 SHALL sustain one result per cycle under continuous x_result_ready_i=1 (simultaneous drain and load).
REQ-024 SHALL never drop, duplicate or reorder a single requester's results; requester order across sources is arbitration order.
REQ-025 SHALL not depend on req_valid_i being stable; requester deasserting before grant loses nothing (no grant issued).
REQ-026 SHALL not combinationally path x_result_ready_i to x_result_valid_o or output fields.
REQ-027 SHALL leave output fields unchanged (not zeroed) when register empties.

Reset
REQ-028 SHALL, on rst_ni low, asynchronously set x_result_valid_o=0, all output fields=0, x_result_src_o=0, rr_q=0.
REQ-029 SHALL drive req_ready_o=0 while rst_ni low; a result in the output register at reset is discarded.
REQ-030 SHALL grant first valid index from 0 on the first cycle after reset release.

Verification
REQ-031 Reset release, req_valid_i=2'b01, id=3, data=0xDEADBEEF, ready=1 -> req_ready_o=01 same cycle; next cycle x_result_valid_o=1, id=3, data=0xDEADBEEF, src=0.
REQ-032 Both requesters valid continuously, ready=1 -> grants alternate 0,1,0,1; one output per cycle; src toggles.
REQ-033 Output full, ready=0 for 3 cycles, both valid -> req_ready_o=00 throughout, output fields stable; ready=1 -> same-cycle grant to rr_q requester, new result next cycle.
REQ-034 Only requester 1 valid, rr_q=0 -> wrap search grants 1; rr_q becomes 0.
REQ-035 rst_ni asserted while x_result_valid_o=1, ready=0 -> valid=0 immediately; after release, pending requester re-granted from index 0.
REQ-036 Single valid pulse, ready=1, no further requests -> valid high exactly 1 cycle, then 0 with fields held.

Source files
------------

// File: rtl/xif_result_arbiter.sv
// xif_result_arbiter
// Round-robin arbiter that funnels coprocessor results from NUM_REQ
// requesters into a single registered X-interface result channel.
// The output stage is one register whose valid bit doubles as its
// full/empty flag; a new result may load in the same cycle the core
// drains the previous one, so throughput is one result per cycle.

module xif_result_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ID_WIDTH = 4,
  localparam int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,

  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]   req_id_i,
  input  logic [NUM_REQ-1:0][31:0]           req_data_i,
  input  logic [NUM_REQ-1:0][4:0]            req_rd_i,
  input  logic [NUM_REQ-1:0][2:0]            req_flags_i,
  input  logic [NUM_REQ-1:0][5:0]            req_exccode_i,

  output logic                               x_result_valid_o,
  input  logic                               x_result_ready_i,
  output logic [ID_WIDTH-1:0]                x_result_id_o,
  output logic [31:0]                        x_result_data_o,
  output logic [4:0]                         x_result_rd_o,
  output logic [2:0]                         x_result_flags_o,
  output logic [5:0]                         x_result_exccode_o,
  output logic [SRC_W-1:0]                   x_result_src_o
);

  logic [SRC_W-1:0] rr_q;
  logic             can_load;
  logic             grant_found;
  logic [SRC_W-1:0] grant_idx;
  logic             do_grant;
  logic [SRC_W-1:0] rr_next;
  int               scan_idx;

  // The output register can accept a new result when it is empty or being drained this cycle.
  assign can_load = !x_result_valid_o || x_result_ready_i;

  // Search for the first valid requester starting at rr_q and wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_q) + k;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = SRC_W'(scan_idx);
      end
    end
  end

  // A grant only happens out of reset; this also keeps req_ready_o low while rst_ni is asserted.
  assign do_grant = rst_ni && can_load && grant_found;

  // One-hot ready back to the winning requester, in the same cycle as the grant.
  always_comb begin
    req_ready_o = '0;
    if (do_grant) begin
      req_ready_o = NUM_REQ'(1) << grant_idx;
    end
  end

  // Pointer moves to just past the winner so every requester gets its turn.
  always_comb begin
    rr_next = grant_idx + SRC_W'(1);
    if (grant_idx == SRC_W'(NUM_REQ - 1)) begin
      rr_next = '0;
    end
  end

  // Output register and round-robin pointer; fields keep their last value when the register empties.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_result_valid_o   <= 1'b0;
      x_result_id_o      <= '0;
      x_result_data_o    <= '0;
      x_result_rd_o      <= '0;
      x_result_flags_o   <= '0;
      x_result_exccode_o <= '0;
      x_result_src_o     <= '0;
      rr_q               <= '0;
    end else if (do_grant) begin
      x_result_valid_o   <= 1'b1;
      x_result_id_o      <= req_id_i[grant_idx];
      x_result_data_o    <= req_data_i[grant_idx];
      x_result_rd_o      <= req_rd_i[grant_idx];
      x_result_flags_o   <= req_flags_i[grant_idx];
      x_result_exccode_o <= req_exccode_i[grant_idx];
      x_result_src_o     <= grant_idx;
      rr_q               <= rr_next;
    end else if (x_result_valid_o && x_result_ready_i) begin
      x_result_valid_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xif_result_arbiter.sv
// tb_xif_result_arbiter
// Self-checking bench: directed scenarios plus a randomized run, all
// compared against a transaction-level model of the arbiter.

module tb_xif_result_arbiter;

  localparam int N   = 2;
  localparam int IDW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]           req_valid;
  logic [N-1:0]           req_ready;
  logic [N-1:0][IDW-1:0]  req_id;
  logic [N-1:0][31:0]     req_data;
  logic [N-1:0][4:0]      req_rd;
  logic [N-1:0][2:0]      req_flags;
  logic [N-1:0][5:0]      req_exc;
  logic                   x_valid;
  logic                   x_ready;
  logic [IDW-1:0]         x_id;
  logic [31:0]            x_data;
  logic [4:0]             x_rd;
  logic [2:0]             x_flags;
  logic [5:0]             x_exc;
  logic [0:0]             x_src;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state: contents of the single output slot and the next-turn pointer.
  logic           m_valid;
  logic [IDW-1:0] m_id;
  logic [31:0]    m_data;
  logic [4:0]     m_rd;
  logic [2:0]     m_flags;
  logic [5:0]     m_exc;
  logic [0:0]     m_src;
  int             m_rr;
  logic [N-1:0]   last_grant;

  always #5 clk = ~clk;

  xif_result_arbiter #(.NUM_REQ(N), .ID_WIDTH(IDW)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .req_valid_i        (req_valid),
    .req_ready_o        (req_ready),
    .req_id_i           (req_id),
    .req_data_i         (req_data),
    .req_rd_i           (req_rd),
    .req_flags_i        (req_flags),
    .req_exccode_i      (req_exc),
    .x_result_valid_o   (x_valid),
    .x_result_ready_i   (x_ready),
    .x_result_id_o      (x_id),
    .x_result_data_o    (x_data),
    .x_result_rd_o      (x_rd),
    .x_result_flags_o   (x_flags),
    .x_result_exccode_o (x_exc),
    .x_result_src_o     (x_src)
  );

  // Who should win this cycle: the slot must be free or draining, then take turns from m_rr.
  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    bit found;
    g = '0;
    found = 0;
    if (rst_n && (!m_valid || x_ready)) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (!found && req_valid[idx]) begin
          g[idx] = 1'b1;
          found = 1;
        end
      end
    end
    return g;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = '0; m_data = '0; m_rd = '0;
    m_flags = '0; m_exc = '0; m_src = '0; m_rr = 0; last_grant = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_clock();
    logic [N-1:0] g;
    g = model_grant();
    last_grant = g;
    for (int r = 0; r < N; r++) begin
      if (g[r]) begin
        m_valid = 1; m_id = req_id[r]; m_data = req_data[r]; m_rd = req_rd[r];
        m_flags = req_flags[r]; m_exc = req_exc[r]; m_src = 1'(r); m_rr = (r + 1) % N;
      end
    end
    if (g == '0 && m_valid && x_ready) m_valid = 0;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
  endtask

  task automatic new_payload(input int r);
    req_id[r] = IDW'($urandom); req_data[r] = $urandom; req_rd[r] = 5'($urandom);
    req_flags[r] = 3'($urandom); req_exc[r] = 6'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; req_valid = '0; x_ready = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    for (int r = 0; r < N; r++) new_payload(r);
    req_valid = '1; x_ready = 1; rst_n = 0;
    model_reset();
    @(negedge clk); #1;
    tests_run++;
    if (x_valid !== 1'b0 || req_ready !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: valid=%b ready=%b, expected 0 and 00", x_valid, req_ready);
    end
    tests_run++;
    if ({x_id, x_data, x_rd, x_flags, x_exc, x_src} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_fields: id=%h data=%h rd=%h src=%h, expected all zero", x_id, x_data, x_rd, x_src);
    end
    req_valid = '0; x_ready = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    new_payload(0); req_id[0] = 4'd3; req_data[0] = 32'hDEADBEEF;
    req_valid = 2'b01; x_ready = 1; #1;
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL single_grant: ready=%b, expected 01", req_ready);
    end
    tick();
    @(negedge clk); req_valid = '0; #1;
    tests_run++;
    if (x_valid !== 1'b1 || x_id !== 4'd3 || x_data !== 32'hDEADBEEF || x_src !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_output: valid=%b id=%h data=%h src=%b, expected 1 3 deadbeef 0", x_valid, x_id, x_data, x_src);
    end
    tick();
    @(negedge clk); #1;
    tests_run++;
    if (x_valid !== 1'b0 || x_data !== 32'hDEADBEEF || x_id !== 4'd3) begin
      tests_failed++;
      $display("[TB] FAIL single_drain: valid=%b data=%h id=%h, expected 0 deadbeef 3", x_valid, x_data, x_id);
    end
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      new_payload(0); new_payload(1);
      req_valid = 2'b11; x_ready = 1; #1;
      tests_run++;
      if (req_ready !== ((c % 2) ? 2'b10 : 2'b01)) begin
        tests_failed++;
        $display("[TB] FAIL alt_grant cycle %0d: ready=%b, expected %b", c, req_ready, (c % 2) ? 2'b10 : 2'b01);
      end
      if (c > 0) begin
        tests_run++;
        if (x_valid !== 1'b1 || x_src !== 1'((c - 1) % 2) || x_data !== m_data) begin
          tests_failed++;
          $display("[TB] FAIL alt_output cycle %0d: valid=%b src=%b data=%h, expected 1 %0d %h", c, x_valid, x_src, x_data, (c - 1) % 2, m_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_data;
    logic [0:0]  held_src;
    logic [N-1:0] exp_g;
    @(negedge clk);
    new_payload(0); new_payload(1);
    req_valid = 2'b11; x_ready = 1;
    tick();
    held_data = m_data; held_src = m_src;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      new_payload(0); new_payload(1);
      x_ready = 0; #1;
      tests_run++;
      if (req_ready !== 2'b00 || x_valid !== 1'b1 || x_data !== held_data || x_src !== held_src) begin
        tests_failed++;
        $display("[TB] FAIL stall cycle %0d: ready=%b valid=%b data=%h src=%b, expected 00 1 %h %b", c, req_ready, x_valid, x_data, x_src, held_data, held_src);
      end
      tick();
    end
    @(negedge clk);
    x_ready = 1; #1;
    exp_g = model_grant();
    tests_run++;
    if (req_ready !== exp_g || exp_g !== (2'b01 << m_rr)) begin
      tests_failed++;
      $display("[TB] FAIL stall_release: ready=%b, expected %b", req_ready, 2'b01 << m_rr);
    end
    tick();
    @(negedge clk); req_valid = '0; #1;
    tests_run++;
    if (x_valid !== 1'b1 || x_src === held_src || x_data !== m_data) begin
      tests_failed++;
      $display("[TB] FAIL stall_newresult: valid=%b src=%b data=%h, expected 1 %b %h", x_valid, x_src, x_data, m_src, m_data);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    new_payload(1); req_valid = 2'b10; x_ready = 1; #1;
    tests_run++;
    if (req_ready !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL wrap_grant: ready=%b, expected 10", req_ready);
    end
    tick();
    @(negedge clk);
    new_payload(0); req_valid = 2'b01; #1;
    tests_run++;
    if (req_ready !== 2'b01 || x_src !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL wrap_pointer: ready=%b src=%b, expected 01 1", req_ready, x_src);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    @(negedge clk);
    new_payload(0); req_valid = 2'b01; x_ready = 0;
    tick();
    @(negedge clk);
    new_payload(1); req_valid = 2'b10; #1;
    tests_run++;
    if (x_valid !== 1'b1 || req_ready !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL midflight_full: valid=%b ready=%b, expected 1 00", x_valid, req_ready);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    tests_run++;
    if (x_valid !== 1'b0 || req_ready !== 2'b00 || x_src !== 1'b0 || x_data !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL midflight_reset: valid=%b ready=%b src=%b data=%h, expected 0 00 0 0", x_valid, req_ready, x_src, x_data);
    end
    @(negedge clk);
    rst_n = 1; new_payload(0); req_valid = 2'b11; #1;
    tests_run++;
    if (req_ready !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL midflight_regrant: ready=%b, expected 01", req_ready);
    end
    tick();
    @(negedge clk); req_valid = '0; #1;
    tests_run++;
    if (x_valid !== 1'b1 || x_src !== 1'b0 || x_data !== req_data[0]) begin
      tests_failed++;
      $display("[TB] FAIL midflight_output: valid=%b src=%b data=%h, expected 1 0 %h", x_valid, x_src, x_data, req_data[0]);
    end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_g;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int r = 0; r < N; r++) begin
        if (last_grant[r] || !req_valid[r]) begin
          req_valid[r] = ($urandom_range(0, 9) < 6);
          new_payload(r);
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[r] = 1'b0;
        end
      end
      x_ready = ($urandom_range(0, 9) < 7);
      #1;
      exp_g = model_grant();
      tests_run++;
      if (req_ready !== exp_g) begin
        tests_failed++;
        $display("[TB] FAIL rand_ready cycle %0d: ready=%b, expected %b", c, req_ready, exp_g);
      end
      tests_run++;
      if (x_valid !== m_valid) begin
        tests_failed++;
        $display("[TB] FAIL rand_valid cycle %0d: valid=%b, expected %b", c, x_valid, m_valid);
      end
      tests_run++;
      if ({x_id, x_data, x_rd, x_flags, x_exc, x_src} !== {m_id, m_data, m_rd, m_flags, m_exc, m_src}) begin
        tests_failed++;
        $display("[TB] FAIL rand_fields cycle %0d: id=%h data=%h rd=%h fl=%h exc=%h src=%b, expected %h %h %h %h %h %b",
                 c, x_id, x_data, x_rd, x_flags, x_exc, x_src, m_id, m_data, m_rd, m_flags, m_exc, m_src);
      end
      tick();
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    req_valid = '0; x_ready = 0;
    req_id = '0; req_data = '0; req_rd = '0; req_flags = '0; req_exc = '0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_wrap();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
